audio_pcm_mixer: RTL

// Downstream of the APU channel generator. Consumes the two 6-bit per-channel

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_rate_gen.sv | 35 +++
 rtl/audio_pcm_mixer.sv | 93 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types for the APU PCM mixer.
// Holds the sample word types and the output saturation helper.
package audio_pkg;

  localparam int LP_FRAC = 8;
  localparam int PCM_W   = 16;

  typedef logic signed [PCM_W-1:0] pcm_t;

  typedef struct packed {
    pcm_t l;
    pcm_t r;
  } pcm_pair_t;

  function automatic pcm_t sat16(
    input logic signed [17:0] v
  );
    if (v > 18'sd32767)  return 16'sh7fff;
    if (v < -18'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/audio_rate_gen.sv
// Fractional phase accumulator producing SAMPLE_HZ ticks from CE_HZ strobes.
// The tick is a registered one-clk pulse, raised only on a ce cycle.
module audio_rate_gen #(
  parameter int CE_HZ     = 4000000,
  parameter int SAMPLE_HZ = 48000
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  output logic tick
);

  logic [31:0] phase;
  logic [31:0] nxt;

  assign nxt = phase + 32'(SAMPLE_HZ);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      tick  <= 1'b0;
    end else if (ce) begin
      if (nxt >= 32'(CE_HZ)) begin
        phase <= nxt - 32'(CE_HZ);
        tick  <= 1'b1;
      end else begin
        phase <= nxt;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_pcm_mixer.sv
// Low-pass, resample, optional DC-block and valid/ready output of the
// two APU channel level sums as 16-bit signed PCM.
import audio_pkg::*;

module audio_pcm_mixer #(
  parameter int CE_HZ     = 4000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int LP_SHIFT  = 4,
  parameter int DC_SHIFT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [5:0]        CH1,
  input  logic [5:0]        CH2,
  input  logic              mute,
  input  logic              dc_block_en,
  output logic signed [15:0] pcm_l,
  output logic signed [15:0] pcm_r,
  output logic              pcm_valid,
  input  logic              pcm_ready,
  output logic              overrun
);

  logic      tick;
  pcm_t      y [2];
  pcm_pair_t pcm;

  audio_rate_gen #(
    .CE_HZ     (CE_HZ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_rate (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .tick  (tick)
  );

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [5:0]         x;
    logic [13:0]        lp;
    logic signed [14:0] d;
    logic signed [17:0] s;
    logic signed [17:0] h;
    logic signed [17:0] s_prev;
    logic signed [17:0] h_prev;

    assign x = (c == 0) ? CH1 : CH2;
    assign d = $signed({1'b0, x, {LP_FRAC{1'b0}}})
             - $signed({1'b0, lp});
    assign s = $signed({3'b000, lp, 1'b0});
    assign h = s - s_prev + h_prev - (h_prev >>> DC_SHIFT);
    assign y[c] = dc_block_en ? sat16(h) : s[15:0];

    always_ff @(posedge clk) begin
      if (reset) begin
        lp <= '0;
      end else if (ce) begin
        lp <= lp + 14'(d >>> LP_SHIFT);
      end
    end

    // Bypass clears the history so re-enabling starts from a clean step.
    always_ff @(posedge clk) begin
      if (reset) begin
        s_prev <= '0;
        h_prev <= '0;
      end else if (tick) begin
        s_prev <= s;
        h_prev <= dc_block_en ? h : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcm       <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (tick) begin
      pcm.l     <= mute ? '0 : y[0];
      pcm.r     <= mute ? '0 : y[1];
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready) overrun <= 1'b1;
    end else if (pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

  assign pcm_l = pcm.l;
  assign pcm_r = pcm.r;

endmodule
